// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, IR type/opcode fields, ALUOp codes.
// Also holds the legal-instruction decode table used in DECODE.
package ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [1:0] TYPE_R   = 2'b00;
    localparam logic [1:0] TYPE_I   = 2'b01;
    localparam logic [1:0] TYPE_MEM = 2'b10;
    localparam logic [1:0] TYPE_BR  = 2'b11;

    localparam logic [3:0] OP_NOT = 4'b0000;
    localparam logic [3:0] OP_BNE = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_LI  = 4'b1001;
    localparam logic [3:0] OP_LWI = 4'b1011;
    localparam logic [3:0] OP_SWI = 4'b1100;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_OPCODE  = 2'b01;
    localparam logic [1:0] ALUOP_SUB     = 2'b10;
    localparam logic [1:0] ALUOP_PASS_R3 = 2'b11;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_branch;
        logic [1:0] alu_op;
        logic [3:0] alu_opcode;
        logic       alu_src_imm;
        logic       addr_load;
        logic       reg_write;
        logic       wb_sel_mem;
        logic       halted;
    } ctrl_out_t;

    function automatic logic is_legal(input logic [1:0] itype, input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        case (itype)
            TYPE_R:   ok = (op <= OP_SLT);
            TYPE_I:   ok = ((op >= OP_ADD) && (op <= OP_SLT)) || (op == OP_LI);
            TYPE_MEM: ok = (op == OP_LWI) || (op == OP_SWI);
            default:  ok = (op == OP_BNE);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// Retired-instruction and memory-stall counters, wrapping modulo 2^WIDTH; cleared by rst.
// Latency: count visible the cycle after the strobe. No backpressure; strobes are sampled every cycle.
module ctrl_perf_counters #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire,
    input  logic             stall,
    output logic [WIDTH-1:0] retired_count,
    output logic [WIDTH-1:0] stall_count
);

    logic [WIDTH-1:0] retired_q, retired_d;
    logic [WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        retired_d = retired_q + WIDTH'(retire);
        stall_d   = stall_q + WIDTH'(stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_count = retired_q;
    assign stall_count   = stall_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 32-bit ALU datapath.
// Latency: 3 (BNE) to 5 (LWI) cycles per instruction, +1 per memory wait cycle; waits on imem/dmem ack.
// Define MULTICYCLE_CTRL_PERF_EN to build the retired/stall counters; otherwise those ports read 0.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            instr_type,
    input  logic [3:0]            opcode,
    input  logic                  zero,
    input  logic                  imem_ack,
    input  logic                  dmem_ack,
    output logic                  imem_req,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic                  ir_load,
    output logic                  pc_inc,
    output logic                  pc_branch,
    output logic [1:0]            alu_op,
    output logic [3:0]            alu_opcode,
    output logic                  alu_src_imm,
    output logic                  addr_load,
    output logic                  reg_write,
    output logic                  wb_sel_mem,
    output logic                  halted,
    output logic [PERF_WIDTH-1:0] retired_count,
    output logic [PERF_WIDTH-1:0] stall_count
);

    logic [2:0] state_q, state_d;
    // Low for the first cycle after reset so every output reads 0 while rst is held.
    logic       active_q, active_d;
    ctrl_out_t  ctl;
    logic       is_lwi;
    logic       is_swi;

    assign is_lwi = (instr_type == TYPE_MEM) && (opcode == OP_LWI);
    assign is_swi = (instr_type == TYPE_MEM) && (opcode == OP_SWI);

    always_comb begin
        state_d  = state_q;
        active_d = 1'b1;
        ctl      = '0;
        if (active_q) begin
            case (state_q)
                ST_FETCH: begin
                    ctl.imem_req = 1'b1;
                    if (imem_ack) begin
                        ctl.ir_load = 1'b1;
                        ctl.pc_inc  = 1'b1;
                        state_d     = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_d = is_legal(instr_type, opcode) ? ST_EXEC : ST_HALT;
                end
                ST_EXEC: begin
                    if (instr_type == TYPE_BR) begin
                        ctl.alu_op    = ALUOP_SUB;
                        ctl.pc_branch = !zero;
                        state_d       = ST_FETCH;
                    end else if (instr_type == TYPE_MEM) begin
                        ctl.alu_op      = ALUOP_PASS_R3;
                        ctl.alu_opcode  = opcode;
                        ctl.alu_src_imm = 1'b1;
                        ctl.addr_load   = 1'b1;
                        state_d         = ST_MEM;
                    end else begin
                        ctl.alu_op      = ALUOP_OPCODE;
                        ctl.alu_opcode  = opcode;
                        ctl.alu_src_imm = (instr_type == TYPE_I);
                        state_d         = ST_WB;
                    end
                end
                ST_MEM: begin
                    ctl.dmem_req = 1'b1;
                    if (is_swi) begin
                        // ALU passes R2 through as store data.
                        ctl.dmem_we    = 1'b1;
                        ctl.alu_op     = ALUOP_OPCODE;
                        ctl.alu_opcode = OP_SWI;
                    end
                    if (dmem_ack) begin
                        state_d = is_swi ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB: begin
                    ctl.reg_write  = 1'b1;
                    ctl.wb_sel_mem = is_lwi;
                    state_d        = ST_FETCH;
                end
                ST_HALT: begin
                    ctl.halted = 1'b1;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    assign imem_req    = ctl.imem_req;
    assign dmem_req    = ctl.dmem_req;
    assign dmem_we     = ctl.dmem_we;
    assign ir_load     = ctl.ir_load;
    assign pc_inc      = ctl.pc_inc;
    assign pc_branch   = ctl.pc_branch;
    assign alu_op      = ctl.alu_op;
    assign alu_opcode  = ctl.alu_opcode;
    assign alu_src_imm = ctl.alu_src_imm;
    assign addr_load   = ctl.addr_load;
    assign reg_write   = ctl.reg_write;
    assign wb_sel_mem  = ctl.wb_sel_mem;
    assign halted      = ctl.halted;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire;
    logic stall;

    // HALT raises neither strobe, so the counters freeze there without extra gating.
    assign retire = active_q &&
                    (((state_q == ST_EXEC) && (instr_type == TYPE_BR)) ||
                     ((state_q == ST_MEM) && is_swi && dmem_ack) ||
                     (state_q == ST_WB));
    assign stall  = (ctl.imem_req && !imem_ack) || (ctl.dmem_req && !dmem_ack);

    ctrl_perf_counters #(
        .WIDTH(PERF_WIDTH)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .retire       (retire),
        .stall        (stall),
        .retired_count(retired_count),
        .stall_count  (stall_count)
    );
`else
    assign retired_count = '0;
    assign stall_count   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: per-cycle expected outputs and counters are
// queued by the stimulus side and popped/compared by an independent monitor on the falling edge.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  instr_type = 2'b00;
    logic [3:0]  opcode = 4'b0000;
    logic        zero = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_branch;
    logic [1:0]  alu_op;
    logic [3:0]  alu_opcode;
    logic        alu_src_imm, addr_load, reg_write, wb_sel_mem, halted;
    logic [31:0] retired_count, stall_count;

    multicycle_ctrl #(.PERF_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr_type(instr_type), .opcode(opcode), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch),
        .alu_op(alu_op), .alu_opcode(alu_opcode), .alu_src_imm(alu_src_imm),
        .addr_load(addr_load), .reg_write(reg_write), .wb_sel_mem(wb_sel_mem),
        .halted(halted), .retired_count(retired_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_branch;
        logic [1:0] alu_op;
        logic [3:0] alu_opcode;
        logic       alu_src_imm;
        logic       addr_load;
        logic       reg_write;
        logic       wb_sel_mem;
        logic       halted;
    } ovec_t;

    typedef struct packed {
        ovec_t       o;
        logic [31:0] ret;
        logic [31:0] stl;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    ovec_t       mon_act;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] m_ret = 0;
    logic [31:0] m_stl = 0;

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic legal_instr(input logic [1:0] t, input logic [3:0] op);
        int o;
        o = int'(op);
        return (t == 2'd0 && o < 8) ||
               (t == 2'd1 && (o inside {[2:7], 9})) ||
               (t == 2'd2 && (o == 11 || o == 12)) ||
               (t == 2'd3 && o == 1);
    endfunction

    // One clock cycle of stimulus plus the outputs expected during it.
    task automatic step(input logic r, input logic [1:0] t, input logic [3:0] op,
                        input logic ia, input logic da, input logic z,
                        input ovec_t o, input bit retire_ev);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; instr_type = t; opcode = op; imem_ack = ia; dmem_ack = da; zero = z;
        e.o   = o;
        e.ret = PERF_ON ? m_ret : 32'd0;
        e.stl = PERF_ON ? m_stl : 32'd0;
        exp_q.push_back(e);
        if (r) begin
            m_ret = 0;
            m_stl = 0;
        end else begin
            if (retire_ev) m_ret = m_ret + 1;
            if ((o.imem_req && !ia) || (o.dmem_req && !da)) m_stl = m_stl + 1;
        end
    endtask

    task automatic do_reset(input int n, input logic late_dack);
        for (int i = 0; i < n; i++)
            step(1'b1, 2'($urandom), 4'($urandom), rb(), late_dack | rb(), rb(), '0, 1'b0);
        step(1'b0, 2'($urandom), 4'($urandom), rb(), late_dack | rb(), rb(), '0, 1'b0);
    endtask

    // fw/mw: memory wait cycles before ack; rst_mem: MEM wait cycle at which reset is raised (-1 none).
    task automatic do_instr(input logic [1:0] t, input logic [3:0] op, input int fw,
                            input int mw, input logic z, input int rst_mem);
        ovec_t o;
        logic  swi;
        swi = (t == 2'd2) && (op == 4'd12);
        for (int i = 0; i < fw; i++) begin
            o = '0; o.imem_req = 1'b1;
            step(1'b0, 2'($urandom), 4'($urandom), 1'b0, rb(), rb(), o, 1'b0);
        end
        o = '0; o.imem_req = 1'b1; o.ir_load = 1'b1; o.pc_inc = 1'b1;
        step(1'b0, 2'($urandom), 4'($urandom), 1'b1, rb(), rb(), o, 1'b0);
        o = '0;
        step(1'b0, t, op, rb(), rb(), rb(), o, 1'b0);
        if (!legal_instr(t, op)) begin
            o = '0; o.halted = 1'b1;
            for (int i = 0; i < 20; i++) step(1'b0, t, op, rb(), rb(), rb(), o, 1'b0);
            step(1'b1, t, op, rb(), rb(), rb(), o, 1'b0);
            do_reset(2, 1'b0);
            return;
        end
        o = '0;
        if (t == 2'd3) begin
            o.alu_op = 2'b10; o.pc_branch = !z;
            step(1'b0, t, op, rb(), rb(), z, o, 1'b1);
            return;
        end
        if (t == 2'd2) begin
            o.alu_op = 2'b11; o.alu_opcode = op; o.alu_src_imm = 1'b1; o.addr_load = 1'b1;
            step(1'b0, t, op, rb(), rb(), rb(), o, 1'b0);
            o = '0; o.dmem_req = 1'b1;
            if (swi) begin
                o.dmem_we = 1'b1; o.alu_op = 2'b01; o.alu_opcode = 4'b1100;
            end
            for (int i = 0; i < mw; i++) begin
                if (i == rst_mem) begin
                    step(1'b1, t, op, rb(), 1'b0, rb(), o, 1'b0);
                    do_reset(3, 1'b1);
                    return;
                end
                step(1'b0, t, op, rb(), 1'b0, rb(), o, 1'b0);
            end
            step(1'b0, t, op, rb(), 1'b1, rb(), o, swi);
            if (swi) return;
        end else begin
            o.alu_op = 2'b01; o.alu_opcode = op; o.alu_src_imm = (t == 2'd1);
            step(1'b0, t, op, rb(), rb(), rb(), o, 1'b0);
        end
        o = '0; o.reg_write = 1'b1; o.wb_sel_mem = (t == 2'd2);
        step(1'b0, t, op, rb(), rb(), rb(), o, 1'b1);
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = {imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_branch, alu_op,
                       alu_opcode, alu_src_imm, addr_load, reg_write, wb_sel_mem, halted};
            total++;
            if (mon_act !== mon_e.o) begin
                bad++;
                $display("FAIL outs cyc=%0d got=%h want=%h", cyc, mon_act, mon_e.o);
            end
            total++;
            if (retired_count !== mon_e.ret) begin
                bad++;
                $display("FAIL retired_count cyc=%0d got=%0d want=%0d", cyc, retired_count, mon_e.ret);
            end
            total++;
            if (stall_count !== mon_e.stl) begin
                bad++;
                $display("FAIL stall_count cyc=%0d got=%0d want=%0d", cyc, stall_count, mon_e.stl);
            end
        end
    end

    initial begin
        logic [1:0] t;
        logic [3:0] op;
        int         k, fw, mw, rm;
        rst = 1'b1;
        do_reset(3, 1'b0);
        do_instr(2'd0, 4'd2, 0, 0, 1'b0, -1);
        do_instr(2'd2, 4'd11, 0, 3, 1'b0, -1);
        do_instr(2'd3, 4'd1, 0, 0, 1'b0, -1);
        do_instr(2'd3, 4'd1, 0, 0, 1'b1, -1);
        do_instr(2'd1, 4'd9, 2, 0, 1'b0, -1);
        do_instr(2'd2, 4'd12, 0, 0, 1'b0, -1);
        do_instr(2'd2, 4'd12, 1, 3, 1'b0, 1);
        do_instr(2'd0, 4'd7, 0, 0, 1'b0, -1);
        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 14));
            case (k)
                0: begin t = 2'($urandom); op = 4'($urandom); end
                1, 2, 3: begin t = 2'd0; op = 4'($urandom_range(0, 7)); end
                4, 5: begin t = 2'd1; op = ($urandom_range(0, 6) == 0) ? 4'd9 : 4'($urandom_range(2, 7)); end
                6, 7, 8: begin t = 2'd2; op = 4'd11; end
                9, 10, 11: begin t = 2'd2; op = 4'd12; end
                default: begin t = 2'd3; op = 4'd1; end
            endcase
            fw = int'($urandom_range(0, 3));
            mw = int'($urandom_range(0, 3));
            rm = (mw > 0 && $urandom_range(0, 19) == 0) ? int'($urandom_range(0, mw - 1)) : -1;
            do_instr(t, op, fw, mw, rb(), rm);
        end
        do_instr(2'd2, 4'd0, 0, 0, 1'b0, -1);
        do_instr(2'd0, 4'd2, 0, 0, 1'b0, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
